// File: rtl/rf_pkg.sv
// Shared definitions for the integer register file and its writeback path.
//   XLEN   : data width of one register
//   NREG   : number of architectural registers (x0 reads as zero)
//   REG_AW : register address width
//   WB_*   : fixed writeback requester indices used by the scheduler
package rf_pkg;

  localparam int XLEN   = 64;
  localparam int NREG   = 32;
  localparam int REG_AW = 5;

  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]   xlen_t;

  localparam int WB_ALU = 0;
  localparam int WB_LSU = 1;
  localparam int WB_MDU = 2;

endpackage

// File: rtl/rf_wb_sched_rr_arbiter.sv
// Combinational round-robin arbiter. The search starts one position after
// the pointer and wraps, so the last winner has lowest priority. The pointer
// register is kept by the instantiating block.
//   req_i       : request vector
//   ptr_i       : index of the previous winner
//   gnt_o       : one-hot grant (all zero when nothing requests)
//   gnt_idx_o   : index of the granted requester
//   gnt_valid_o : some requester was granted
module rr_arbiter #(
  parameter  int N  = 3,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] gnt_idx_o,
  output logic          gnt_valid_o
);

  // NOTE: every output gets a default before the search loop, so no path
  // through the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    int idx;
    gnt_o       = '0;
    gnt_idx_o   = '0;
    gnt_valid_o = 1'b0;
    idx         = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(ptr_i) + k) % N;
      if (!gnt_valid_o && req_i[idx]) begin
        gnt_o[idx]  = 1'b1;
        gnt_idx_o   = IW'(idx);
        gnt_valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rf_wb_sched.sv
// Writeback scheduler for the 32 x XLEN integer register file. Shares the
// single write port among NREQ writeback sources round-robin, registers the
// winning write into the file, and keeps a pending-write scoreboard for
// decode's RAW/WAW checks.
//   clk, rst               : clock, asynchronous active-high reset
//   req_valid/req_ready    : per-requester handshake (ready is combinational)
//   req_rdaddr, req_data   : per-requester destination and write data
//   issue_valid/rdaddr     : decode issues an instruction writing rdaddr
//   rs1addr/rs2addr        : sources checked by decode
//   rs1_busy/rs2_busy      : source has a write still pending
//   rf_we/rf_waddr/rf_wdata: registered register-file write port
//   busy_vec               : scoreboard, bit r = x_r has a write pending
module rf_wb_sched
  import rf_pkg::*;
#(
  parameter int NREQ = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NREQ-1:0]             req_valid,
  output logic [NREQ-1:0]             req_ready,
  input  logic [NREQ-1:0][REG_AW-1:0] req_rdaddr,
  input  logic [NREQ-1:0][XLEN-1:0]   req_data,
  input  logic                        issue_valid,
  input  logic [REG_AW-1:0]           issue_rdaddr,
  input  logic [REG_AW-1:0]           rs1addr,
  input  logic [REG_AW-1:0]           rs2addr,
  output logic                        rs1_busy,
  output logic                        rs2_busy,
  output logic                        rf_we,
  output logic [REG_AW-1:0]           rf_waddr,
  output logic [XLEN-1:0]             rf_wdata,
  output logic [NREG-1:0]             busy_vec
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [IW-1:0]   ptr_q;
  logic [NREQ-1:0] gnt;
  logic [IW-1:0]   gnt_idx;
  logic            gnt_valid;
  logic            hs;
  reg_addr_t       win_addr;
  xlen_t           win_data;
  logic            we_q;
  reg_addr_t       waddr_q;
  xlen_t           wdata_q;
  logic [NREG-1:0] busy_q, busy_d;

  rr_arbiter #(.N(NREQ)) u_arb (
    .req_i       (req_valid),
    .ptr_i       (ptr_q),
    .gnt_o       (gnt),
    .gnt_idx_o   (gnt_idx),
    .gnt_valid_o (gnt_valid)
  );

  // Grants are suppressed while reset is held so nothing upstream retires a
  // writeback that the output stage is about to drop.
  assign req_ready = rst ? '0 : gnt;
  assign hs        = gnt_valid & ~rst;

  // One-hot AND-OR mux of the winner's address and data.
  always_comb begin
    win_addr = '0;
    win_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        win_addr = win_addr | req_rdaddr[i];
        win_data = win_data | req_data[i];
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q   <= IW'(NREQ - 1);
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      // x0 writes still consume a grant and move the pointer, but never
      // reach the file.
      we_q <= hs && (win_addr != '0);
      if (hs) begin
        ptr_q   <= gnt_idx;
        waddr_q <= win_addr;
        wdata_q <= win_data;
      end
    end
  end

  // Clear on commit, then set on issue: when both hit one register the
  // newer producer keeps it pending. Bit 0 is forced low last.
  always_comb begin
    busy_d = busy_q;
    if (we_q) busy_d[waddr_q] = 1'b0;
    if (issue_valid && issue_rdaddr != '0) busy_d[issue_rdaddr] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // NOTE: the scoreboard is a plain flop vector, not a RAM, so it takes the
  // asynchronous reset and every pending bit is dropped with the pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign rf_we    = we_q;
  assign rf_waddr = waddr_q;
  assign rf_wdata = wdata_q;
  assign busy_vec = busy_q;
  assign rs1_busy = busy_q[rs1addr];
  assign rs2_busy = busy_q[rs2addr];

endmodule

// File: tb/tb_rf_wb_sched.sv
// Self-checking bench for rf_wb_sched. Inputs are driven 1 time unit after
// the rising edge; outputs are checked on the falling edge. A bench-side
// model (pointer, scoreboard bits) predicts the grant, and the expected
// register-file write for the next cycle is pushed to a queue and popped
// when the DUT presents it.
module tb_rf_wb_sched;

  localparam int NREQ = 3;

  typedef struct packed {
    logic        we;
    logic [4:0]  addr;
    logic [63:0] data;
  } wb_t;

  logic                  clk;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0][4:0]  req_rdaddr;
  logic [NREQ-1:0][63:0] req_data;
  logic                  issue_valid;
  logic [4:0]            issue_rdaddr;
  logic [4:0]            rs1addr, rs2addr;
  logic                  rs1_busy, rs2_busy;
  logic                  rf_we;
  logic [4:0]            rf_waddr;
  logic [63:0]           rf_wdata;
  logic [31:0]           busy_vec;

  int          n_cmp = 0;
  int          n_err = 0;
  int          m_ptr;
  logic [31:0] m_busy;
  wb_t         exp_q[$];

  rf_wb_sched #(.NREQ(NREQ)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_rdaddr   (req_rdaddr),
    .req_data     (req_data),
    .issue_valid  (issue_valid),
    .issue_rdaddr (issue_rdaddr),
    .rs1addr      (rs1addr),
    .rs2addr      (rs2addr),
    .rs1_busy     (rs1_busy),
    .rs2_busy     (rs2_busy),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .busy_vec     (busy_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    req_valid    = '0;
    req_rdaddr   = '0;
    req_data     = '0;
    issue_valid  = 1'b0;
    issue_rdaddr = '0;
  endtask

  // Asserts reset at the current time, checks the asynchronous clear, and
  // releases one cycle later, just after a rising edge.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_we", rf_we, 0);
    check("rst_waddr", rf_waddr, 0);
    check("rst_wdata", rf_wdata, 0);
    check("rst_busy_vec", busy_vec, 0);
    check("rst_rs1_busy", rs1_busy, 0);
    check("rst_rs2_busy", rs2_busy, 0);
    check("rst_ready", req_ready, 0);
    m_ptr  = NREQ - 1;
    m_busy = '0;
    exp_q.delete();
    exp_q.push_back('{we: 1'b0, addr: 5'd0, data: 64'd0});
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // One clock: check the current cycle against the model, then advance the
  // model across the next rising edge.
  task automatic step();
    wb_t cur, nxt;
    int  win;
    logic [NREQ-1:0] exp_rdy;
    @(negedge clk);
    win = -1;
    for (int k = 1; k <= NREQ; k++) begin
      int idx;
      idx = (m_ptr + k) % NREQ;
      if (win < 0 && req_valid[idx]) win = idx;
    end
    exp_rdy = '0;
    if (win >= 0) exp_rdy[win] = 1'b1;
    check("req_ready", req_ready, exp_rdy);

    cur = exp_q.pop_front();
    check("rf_we", rf_we, cur.we);
    check("rf_waddr", rf_waddr, cur.addr);
    check("rf_wdata", rf_wdata, cur.data);
    check("busy_vec", busy_vec, m_busy);
    check("rs1_busy", rs1_busy, m_busy[rs1addr]);
    check("rs2_busy", rs2_busy, m_busy[rs2addr]);

    if (issue_valid)
      assert (!m_busy[issue_rdaddr])
      else $error("protocol: issue to pending register x%0d", issue_rdaddr);

    if (cur.we) m_busy[cur.addr] = 1'b0;
    if (issue_valid && issue_rdaddr != 5'd0) m_busy[issue_rdaddr] = 1'b1;
    if (win >= 0) begin
      nxt.we   = (req_rdaddr[win] != 5'd0);
      nxt.addr = req_rdaddr[win];
      nxt.data = req_data[win];
      m_ptr    = win;
    end else begin
      nxt.we   = 1'b0;
      nxt.addr = cur.addr;
      nxt.data = cur.data;
    end
    exp_q.push_back(nxt);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    rs1addr = '0;
    rs2addr = '0;
    @(posedge clk);
    #1;
    req_valid = '1;          // ready must stay low during reset
    do_reset();
    idle_inputs();

    // Single write from the ALU.
    req_valid[0]  = 1'b1;
    req_rdaddr[0] = 5'd5;
    req_data[0]   = 64'hDEAD_BEEF;
    step();
    idle_inputs();
    step();
    step();

    // Full contention straight out of reset.
    do_reset();
    req_valid  = '1;
    req_rdaddr = {5'd3, 5'd2, 5'd1};
    for (int c = 0; c < 6; c++) begin
      req_data = {64'h300 + 64'(c), 64'h200 + 64'(c), 64'h100 + 64'(c)};
      step();
    end
    idle_inputs();
    step();

    // x0 write from LSU: granted, no rf_we, pointer moves to 1.
    req_valid[1] = 1'b1;
    req_data[1]  = 64'h1234;
    step();
    idle_inputs();
    req_valid  = '1;
    req_rdaddr = {5'd12, 5'd11, 5'd10};
    step();
    idle_inputs();
    step();

    // Scoreboard lifecycle on x7.
    rs1addr      = 5'd7;
    issue_valid  = 1'b1;
    issue_rdaddr = 5'd7;
    step();
    idle_inputs();
    step();
    step();
    step();
    req_valid[2]  = 1'b1;
    req_rdaddr[2] = 5'd7;
    req_data[2]   = 64'h7777_0007;
    step();
    idle_inputs();
    step();
    step();

    // Commit to x9 coincides with issue of x9: set wins.
    rs2addr       = 5'd9;
    req_valid[0]  = 1'b1;
    req_rdaddr[0] = 5'd9;
    req_data[0]   = 64'h9999;
    step();
    idle_inputs();
    issue_valid  = 1'b1;
    issue_rdaddr = 5'd9;
    step();
    idle_inputs();
    step();

    // Build busy_vec = 0x0F00, then reset while a write sits in the output stage.
    foreach (issue_rdaddr[i]) ;
    for (int r = 8; r <= 11; r++) begin
      if (r != 9) begin
        issue_valid  = 1'b1;
        issue_rdaddr = 5'(r);
        step();
      end
    end
    idle_inputs();
    req_valid[1]  = 1'b1;
    req_rdaddr[1] = 5'd20;
    req_data[1]   = 64'h2020;
    step();
    idle_inputs();
    #2;
    check("pre_rst_we", rf_we, exp_q[0].we);
    check("pre_rst_busy", busy_vec, m_busy);
    do_reset();
    req_valid  = '1;
    req_rdaddr = {5'd3, 5'd2, 5'd1};
    step();
    step();
    idle_inputs();
    step();

    // Random legal traffic.
    for (int c = 0; c < 60; c++) begin
      int r;
      req_valid = NREQ'($urandom);
      for (int i = 0; i < NREQ; i++) begin
        req_rdaddr[i] = 5'($urandom);
        req_data[i]   = {$urandom, $urandom};
      end
      r            = $urandom_range(1, 31);
      issue_rdaddr = 5'(r);
      issue_valid  = ($urandom_range(0, 1) == 1) && !m_busy[r];
      rs1addr      = 5'($urandom);
      rs2addr      = 5'($urandom);
      step();
    end
    idle_inputs();
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rf_wb_sched.md
# rf_wb_sched

Writeback scheduler for the 32×64-bit integer register file. It shares the file's single write port between NREQ writeback sources using round-robin arbitration, and keeps a pending-write scoreboard for the decode stage's RAW/WAW hazard checks. It sits between the execution/writeback units and the register file, and drives the file's write enable, write address and write data.

## Interface
- NREQ, 3, number of writeback requesters (index 0 = ALU, 1 = LSU load return, 2 = MUL/DIV)
- XLEN, 64, data width
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- req_valid  in  NREQ  requester i holds a valid writeback
- req_ready  out  NREQ  requester i is granted this cycle; handshake = valid & ready
- req_rdaddr  in  NREQ×5  destination register per requester
- req_data  in  NREQ×XLEN  write data per requester
- issue_valid  in  1  decode issues an instruction that writes issue_rdaddr
- issue_rdaddr  in  5  destination of the issuing instruction
- rs1addr, rs2addr  in  5 each  source registers being checked by decode
- rs1_busy, rs2_busy  out  1 each  source register has a write still pending
- rf_we  out  1  register-file write enable
- rf_waddr  out  5  register-file write address
- rf_wdata  out  XLEN  register-file write data
- busy_vec  out  32  scoreboard state, bit r = x_r has a write pending

## Operation
- Arbitration: combinational round-robin over req_valid. Search starts at ptr+1 mod NREQ. At most one req_ready bit is high, and only for a valid requester. ptr ← granted index on every handshake; ptr holds when there is no grant.
- The register file always accepts a write, so the arbiter has no backpressure. A granted requester completes its handshake in the same cycle.
- Output stage: a single register holding we/waddr/wdata, loaded on every cycle.
  - On a handshake it loads the winner's rdaddr and data, with we = (rdaddr != 0).
  - With no handshake, we = 0; waddr and wdata hold their previous values.
- Requests to x0 are accepted and consume a grant, but never assert rf_we.
- Scoreboard, 32 bits, with bit 0 hardwired to 0:
  - set: issue_valid & issue_rdaddr != 0
  - clear: rf_we & bit == rf_waddr
  - If set and clear hit the same register in the same cycle, set wins (newer producer).
- Only one write may be outstanding per register. Decode stalls issue when busy_vec[issue_rdaddr] = 1. Issue to a busy register is a protocol violation, flagged by a bench assertion; the RTL behaviour in that case is undefined.
- rsN_busy = busy_vec[rsNaddr], from registered state with no bypass. rsN_busy is 0 when rsNaddr = 0.

## Timing
- Handshake in cycle N → rf_we/rf_waddr/rf_wdata valid throughout cycle N+1.
- The register file writes at the end of N+1, and the scoreboard bit clears on that same edge. rsN_busy is therefore low from cycle N+2, which matches the file's synchronous read returning the new value in N+2.
- Issue in cycle M → busy bit set and visible on rsN_busy from M+1.
- Throughput: one writeback per cycle. Under full contention each requester is granted at least once every NREQ cycles.
- Reset values: rf_we = 0, rf_waddr = 0, rf_wdata = 0, busy_vec = 0, rs1_busy = rs2_busy = 0, ptr = NREQ-1 (requester 0 wins first).
- req_ready is combinational and is 0 while rst is asserted.
- Reset mid-operation: a write held in the output stage is dropped (no rf_we after reset) and all pending scoreboard bits are lost. Upstream units are flushed by the same reset.

## Structure
- The shared package rf_pkg holds:
  - constants XLEN = 64, NREG = 32, REG_AW = 5
  - typedefs reg_addr_t (logic [4:0]) and xlen_t (logic [63:0])
  - the requester index constants WB_ALU = 0, WB_LSU = 1, WB_MDU = 2
- Sub-module rr_arbiter (parameter N): combinational one-hot grant from a request vector and the current pointer, plus the grant index output. The pointer register lives in rf_wb_sched.
- Scoreboard and output stage are inline in rf_wb_sched.

## Test plan
- Single write: req 0 valid, rd = 5, data = 0xDEAD_BEEF in cycle 1 → req_ready[0] = 1 in cycle 1; rf_we = 1, rf_waddr = 5, rf_wdata = 0xDEAD_BEEF in cycle 2; rf_we = 0 in cycle 3.
- Contention: all three requesters valid continuously from reset, rd = 1/2/3 → grant order 0,1,2,0,1,2; rf_waddr sequence 1,2,3,1,2,3 on consecutive cycles with no bubbles.
- x0 suppression: req 1 with rd = 0 → req_ready[1] = 1, rf_we stays 0, busy_vec unchanged, and ptr advances to 1.
- Scoreboard lifecycle: issue rd = 7 in cycle 1 → rs1_busy = 1 for rs1addr = 7 from cycle 2; req 2 writes rd = 7, handshake in cycle 5 → rf_we in cycle 6, rs1_busy = 0 from cycle 7.
- Simultaneous set/clear: a write to rd = 9 commits (rf_we, waddr = 9) in the same cycle as issue of rd = 9 → busy_vec[9] = 1 afterwards.
- Async reset while the output stage holds we = 1 and busy_vec = 0x0000_0F00 → immediately rf_we = 0 and busy_vec = 0; the first grant after release goes to requester 0.
